fractional_divider_arbiter: RTL



---
 rtl/fractional_divider_arbiter_pkg.sv | 21 ++
 rtl/fractional_divider_arbiter_if.sv | 29 ++
 rtl/fractional_divider_arbiter_picker.sv | 32 +++
 rtl/fractional_divider_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/fractional_divider_arbiter_pkg.sv
// Shared definitions for the fractional divider arbiter: FSM encoding,
// default parameters and width helpers.
package fractional_divider_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int N_DEF   = 11;
  localparam int M_DEF   = 4;
  localparam int TMO_DEF = 2 * N_DEF + 4;

  // Index width that stays legal for a single requester.
  function automatic int id_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/fractional_divider_arbiter_if.sv
// Requester-side bundle: request operands in, one-hot handshakes and result out.
interface fractional_divider_arbiter_if
  import fractional_divider_arbiter_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
);
  localparam int ID_W = id_width(M);

  logic [M-1:0]   req_valid;
  logic [M*N-1:0] req_dividend;
  logic [M*N-1:0] req_divisor;
  logic [M-1:0]   req_ready;
  logic [M-1:0]   rsp_valid;
  logic [N-1:0]   rsp_quotient;
  logic           rsp_err;
  logic [ID_W-1:0] rsp_id;

  modport master (
    output req_valid, req_dividend, req_divisor,
    input  req_ready, rsp_valid, rsp_quotient, rsp_err, rsp_id
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor,
    output req_ready, rsp_valid, rsp_quotient, rsp_err, rsp_id
  );

endinterface

// File: rtl/fractional_divider_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_priority_picker
  import fractional_divider_arbiter_pkg::*;
#(
  parameter int M    = M_DEF,
  parameter int ID_W = id_width(M)
) (
  input  logic [M-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [M-1:0]    o_grant,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);

  logic w_found;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < M; k++) begin
      if (!w_found && i_req[(int'(i_ptr) + k) % M]) begin
        w_found                           = 1'b1;
        o_grant[(int'(i_ptr) + k) % M]    = 1'b1;
        o_idx                             = ID_W'((int'(i_ptr) + k) % M);
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/fractional_divider_arbiter.sv
// Shares one serial fractional divider among M requesters: round-robin accept,
// launch, wait with watchdog, return the quotient to the originating requester.
module fractional_divider_arbiter
  import fractional_divider_arbiter_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int M   = M_DEF,
  parameter int TMO = 2 * N + 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  fractional_divider_arbiter_if.slave   req_if,
  output logic                          o_busy,
  output logic                          o_div_rst,
  output logic                          o_div_start,
  output logic [N-1:0]                  o_div_dividend,
  output logic [N-1:0]                  o_div_divisor,
  input  logic [N-1:0]                  i_div_quotient,
  input  logic                          i_div_done
);

  localparam int ID_W = id_width(M);
  localparam int WD_W = $clog2(TMO + 1);

  state_e          r_state;
  state_e          w_next;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_id;
  logic [ID_W-1:0] r_rsp_id;
  logic [N-1:0]    r_dividend;
  logic [N-1:0]    r_divisor;
  logic [N-1:0]    r_quot;
  logic            r_err;
  logic [WD_W-1:0] r_wdog;

  logic [M-1:0]    w_grant;
  logic [ID_W-1:0] w_idx;
  logic            w_any;
  logic            w_timeout;

  rr_priority_picker #(.M(M), .ID_W(ID_W)) u_picker (
    .i_req   (req_if.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign o_div_rst = ~rst_n;
  assign w_timeout = (r_wdog == WD_W'(TMO - 1));

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_next = ST_LAUNCH;
      ST_LAUNCH: w_next = ST_WAIT;
      ST_WAIT:   if (i_div_done || w_timeout) w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_id       <= '0;
      r_rsp_id   <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_err      <= 1'b0;
      r_wdog     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_id       <= w_idx;
            r_dividend <= req_if.req_dividend[int'(w_idx) * N +: N];
            r_divisor  <= req_if.req_divisor[int'(w_idx) * N +: N];
          end
        end
        ST_LAUNCH: r_wdog <= '0;
        ST_WAIT: begin
          // A real completion wins over a timeout landing on the same cycle.
          if (i_div_done) begin
            r_quot   <= i_div_quotient;
            r_err    <= 1'b0;
            r_rsp_id <= r_id;
          end else if (w_timeout) begin
            r_quot   <= '0;
            r_err    <= 1'b1;
            r_rsp_id <= r_id;
          end else begin
            r_wdog   <= r_wdog + 1'b1;
          end
        end
        ST_RESP: begin
          if (int'(r_id) == M - 1) r_ptr <= '0;
          else                     r_ptr <= r_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Acceptance is Mealy; gating with rst_n keeps every output low during reset.
  always_comb begin
    req_if.req_ready    = '0;
    req_if.rsp_valid    = '0;
    if (r_state == ST_IDLE && rst_n) req_if.req_ready = w_grant;
    if (r_state == ST_RESP)          req_if.rsp_valid[r_id] = 1'b1;
    req_if.rsp_quotient = r_quot;
    req_if.rsp_err      = r_err;
    req_if.rsp_id       = r_rsp_id;
    o_busy              = (r_state != ST_IDLE);
    o_div_start         = (r_state == ST_LAUNCH);
    o_div_dividend      = r_dividend;
    o_div_divisor       = r_divisor;
  end

endmodule
